// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
package whack_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPlaying  = 2'd1,
    StLockout  = 2'd2,
    StGameOver = 2'd3
  } state_e;

  localparam int unsigned NUM_HOLES = 5;
  localparam logic [2:0]  NO_MOLE   = 3'd5;

endpackage

// File: rtl/game_timer.sv
// Game clock: per-second cycle counter plus seconds-remaining down-counter.
// o_expire flags the edge whose decrement takes the remaining time to zero.
module game_timer #(
  parameter int unsigned CLKS_PER_SEC = 100000000,
  parameter int unsigned GAME_SECONDS = 30
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_enable,
  output logic [5:0] o_time_left,
  output logic       o_expire
);

  localparam int unsigned     CntW    = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [CntW-1:0] SecLast = CntW'(CLKS_PER_SEC - 1);

  logic [CntW-1:0] sec_q, sec_d;
  logic [5:0]      time_q, time_d;
  logic            wrap;

  always_comb begin
    wrap   = i_enable && (sec_q == SecLast);
    sec_d  = sec_q;
    time_d = time_q;
    if (i_load) begin
      sec_d  = '0;
      time_d = 6'(GAME_SECONDS);
    end else if (i_enable) begin
      sec_d = wrap ? '0 : sec_q + 1'b1;
      if (wrap && (time_q != 6'd0)) begin
        time_d = time_q - 6'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sec_q  <= '0;
      time_q <= '0;
    end else begin
      sec_q  <= sec_d;
      time_q <= time_d;
    end
  end

  assign o_time_left = time_q;
  assign o_expire    = wrap && !i_load && (time_q == 6'd1);

endmodule

// File: rtl/whack_game_controller.sv
// Whack-a-mole round sequencer: game FSM, button lockout, mole latch and score.
// Judgement strobes and the new-position request are registered one-cycle pulses.
module whack_game_controller
  import whack_pkg::*;
#(
  parameter int unsigned CLKS_PER_SEC   = 100000000,
  parameter int unsigned GAME_SECONDS   = 30,
  parameter int unsigned LOCKOUT_CYCLES = 25000000,
  parameter int unsigned SCORE_W        = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [NUM_HOLES-1:0] i_btn,
  input  logic [2:0]           i_mole_position,
  input  logic                 i_position_changed,
  output logic                 o_change_position,
  output logic                 o_mole_visible,
  output logic [2:0]           o_mole_hole,
  output logic [SCORE_W-1:0]   o_score,
  output logic [5:0]           o_time_left,
  output logic                 o_game_active,
  output logic                 o_game_over,
  output logic                 o_hit,
  output logic                 o_miss
);

  localparam int unsigned    LkW    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LkW-1:0] LkLast = LkW'(LOCKOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [LkW-1:0]     lk_q, lk_d;
  logic [2:0]         hole_q, hole_d;
  logic               armed_q, armed_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               hit_q, hit_d, miss_q, miss_d, chg_q, chg_d;

  logic active, start_ev, pos_ev, judge, is_hit, is_miss, expire;

  assign active   = (state_q == StPlaying) || (state_q == StLockout);
  assign start_ev = i_start && !active;
  assign pos_ev   = i_position_changed && active;
  // Expiry on the same edge suppresses judging entirely.
  assign judge    = (state_q == StPlaying) && armed_q && (i_btn != '0) && !expire;
  assign is_hit   = judge && (i_btn == (NUM_HOLES'(1) << hole_q));
  assign is_miss  = judge && !is_hit;

  game_timer #(
    .CLKS_PER_SEC (CLKS_PER_SEC),
    .GAME_SECONDS (GAME_SECONDS)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (start_ev),
    .i_enable    (active),
    .o_time_left (o_time_left),
    .o_expire    (expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StGameOver: begin
        if (i_start) state_d = StPlaying;
      end
      StPlaying: begin
        if (expire)                 state_d = StGameOver;
        else if (is_hit || is_miss) state_d = StLockout;
      end
      StLockout: begin
        if (expire)              state_d = StGameOver;
        else if (lk_q == LkLast) state_d = StPlaying;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_game_active  = active;
    o_game_over    = (state_q == StGameOver);
    o_mole_visible = armed_q && active;
  end

  always_comb begin
    lk_d    = (state_q == StLockout) ? lk_q + 1'b1 : '0;
    hole_d  = pos_ev ? i_mole_position : hole_q;
    score_d = score_q;
    if (start_ev) begin
      score_d = '0;
    end else if (is_hit && (score_q != '1)) begin
      score_d = score_q + 1'b1;
    end
    // Hit clears first so a coincident new position re-arms.
    armed_d = armed_q;
    if (start_ev || is_hit) armed_d = 1'b0;
    if (pos_ev)             armed_d = (i_mole_position < 3'(NUM_HOLES));
    if (expire)             armed_d = 1'b0;
    chg_d  = start_ev || is_hit;
    hit_d  = is_hit;
    miss_d = is_miss;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lk_q    <= '0;
      hole_q  <= NO_MOLE;
      armed_q <= 1'b0;
      score_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      lk_q    <= lk_d;
      hole_q  <= hole_d;
      armed_q <= armed_d;
      score_q <= score_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      chg_q   <= chg_d;
    end
  end

  assign o_mole_hole       = hole_q;
  assign o_score           = score_q;
  assign o_hit             = hit_q;
  assign o_miss            = miss_q;
  assign o_change_position = chg_q;

endmodule

// File: tb/tb_whack_game_controller.sv
// Directed bench for whack_game_controller: judgement strobes go through a scoreboard
// queue checked by an independent monitor; state outputs are checked inline.
module tb_whack_game_controller;

  localparam int unsigned CPS = 10;
  localparam int unsigned GS  = 3;
  localparam int unsigned LK  = 4;
  localparam int unsigned SW  = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    btn   = 5'd0;
  logic [2:0]    mpos  = 3'd5;
  logic          pchg  = 1'b0;
  logic          o_change_position, o_mole_visible, o_game_active, o_game_over, o_hit, o_miss;
  logic [2:0]    o_mole_hole;
  logic [SW-1:0] o_score;
  logic [5:0]    o_time_left;

  whack_game_controller #(
    .CLKS_PER_SEC   (CPS),
    .GAME_SECONDS   (GS),
    .LOCKOUT_CYCLES (LK),
    .SCORE_W        (SW)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_start            (start),
    .i_btn              (btn),
    .i_mole_position    (mpos),
    .i_position_changed (pchg),
    .o_change_position  (o_change_position),
    .o_mole_visible     (o_mole_visible),
    .o_mole_hole        (o_mole_hole),
    .o_score            (o_score),
    .o_time_left        (o_time_left),
    .o_game_active      (o_game_active),
    .o_game_over        (o_game_over),
    .o_hit              (o_hit),
    .o_miss             (o_miss)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_hit;
    int unsigned edge_no;
    logic [1:0]  score;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [2:0] gen_pos = 3'd2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Drive one cycle from a falling edge; the 1-cycle generator answers any request.
  task automatic cyc(input logic [4:0] b, input logic s, input logic fv, input logic [2:0] fp);
    btn   = b;
    start = s;
    pchg  = o_change_position || fv;
    mpos  = fv ? fp : gen_pos;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(5'd0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic press(input logic [4:0] b);
    cyc(b, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic expect_press(input logic [4:0] b, input bit h, input logic [1:0] sc);
    exp_t e;
    e.is_hit  = h;
    e.edge_no = edge_n + 1;
    e.score   = sc;
    sb_q.push_back(e);
    cyc(b, 1'b0, 1'b0, 3'd0);
  endtask

  // Monitor: every strobe must match the head of the scoreboard, on the expected edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_hit || o_miss) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: hit=%0b miss=%0b at edge %0d, required none",
                   o_hit, o_miss, edge_n);
        end else begin
          mon_e = sb_q.pop_front();
          if (o_hit !== mon_e.is_hit || o_miss !== !mon_e.is_hit ||
              o_change_position !== mon_e.is_hit || o_score !== mon_e.score ||
              edge_n != mon_e.edge_no) begin
            bad++;
            $display("FAIL strobe: hit=%0b miss=%0b chg=%0b score=%0d edge=%0d, required hit=%0b score=%0d edge=%0d",
                     o_hit, o_miss, o_change_position, o_score, edge_n,
                     mon_e.is_hit, mon_e.score, mon_e.edge_no);
          end
        end
      end else if (sb_q.size() != 0 && edge_n >= sb_q[0].edge_no) begin
        mon_e = sb_q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_strobe: none at edge %0d, required hit=%0b", edge_n, mon_e.is_hit);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    #23;
    check("rst_score", 32'(o_score), 0);
    check("rst_time", 32'(o_time_left), 0);
    check("rst_hole", 32'(o_mole_hole), 5);
    check("rst_flags", 32'({o_game_active, o_game_over, o_mole_visible, o_hit, o_miss,
                             o_change_position}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("idle_active", 32'(o_game_active), 0);

    gen_pos = 3'd2;
    cyc(5'd0, 1'b1, 1'b0, 3'd0);                   // S: start
    check("start_chg", 32'(o_change_position), 1);
    check("start_active", 32'(o_game_active), 1);
    check("start_time", 32'(o_time_left), 3);
    check("start_score", 32'(o_score), 0);
    idle(1);                                       // S+1: mole 2 latched
    check("armed_visible", 32'(o_mole_visible), 1);
    check("armed_hole", 32'(o_mole_hole), 2);
    check("chg_one_cycle", 32'(o_change_position), 0);
    expect_press(5'b00100, 1'b1, 2'd1);            // S+2: hit
    check("hit_score", 32'(o_score), 1);
    idle(1);                                       // S+3
    press(5'b00100);                               // S+4: ignored in lockout
    idle(1);                                       // S+5
    press(5'b00100);                               // S+6: last lockout edge, ignored
    expect_press(5'b01000, 1'b0, 2'd1);            // S+7: wrong hole
    check("miss_visible", 32'(o_mole_visible), 1);
    check("miss_score", 32'(o_score), 1);
    idle(4);                                       // S+8..S+11
    expect_press(5'b00110, 1'b0, 2'd1);            // S+12: multi-bit
    idle(4);                                       // S+13..S+16
    cyc(5'd0, 1'b0, 1'b1, 3'd5);                   // S+17: no mole
    check("nomole_visible", 32'(o_mole_visible), 0);
    check("nomole_hole", 32'(o_mole_hole), 5);
    press(5'b00100);                               // S+18
    press(5'b10000);                               // S+19
    cyc(5'd0, 1'b0, 1'b1, 3'd1);                   // S+20
    check("rearm_visible", 32'(o_mole_visible), 1);
    check("time_at_20", 32'(o_time_left), 1);
    idle(9);                                       // S+21..S+29
    check("time_at_29", 32'(o_time_left), 1);
    check("over_at_29", 32'(o_game_over), 0);
    press(5'b00010);                               // S+30: expiry beats press
    check("exp_time", 32'(o_time_left), 0);
    check("exp_over", 32'(o_game_over), 1);
    check("exp_active", 32'(o_game_active), 0);
    check("exp_visible", 32'(o_mole_visible), 0);
    check("exp_score_hold", 32'(o_score), 1);
    check("exp_hole_hold", 32'(o_mole_hole), 1);
    press(5'b00010);                               // S+31: ignored after game
    cyc(5'd0, 1'b0, 1'b1, 3'd3);                   // S+32: strobe ignored
    check("over_hole_hold", 32'(o_mole_hole), 1);

    gen_pos = 3'd0;
    cyc(5'd0, 1'b1, 1'b0, 3'd0);                   // T: restart
    check("restart_score", 32'(o_score), 0);
    check("restart_time", 32'(o_time_left), 3);
    check("restart_chg", 32'(o_change_position), 1);
    check("restart_over", 32'(o_game_over), 0);
    idle(1);                                       // T+1
    expect_press(5'b00001, 1'b1, 2'd1);            // T+2
    idle(4);
    expect_press(5'b00001, 1'b1, 2'd2);            // T+7
    idle(4);
    expect_press(5'b00001, 1'b1, 2'd3);            // T+12
    idle(4);
    expect_press(5'b00001, 1'b1, 2'd3);            // T+17: saturated
    check("sat_score", 32'(o_score), 3);
    idle(1);                                       // T+18: mid-lockout
    #2 rst_n = 1'b0;
    #1;
    check("arst_active", 32'(o_game_active), 0);
    check("arst_score", 32'(o_score), 0);
    check("arst_hole", 32'(o_mole_hole), 5);
    check("arst_time", 32'(o_time_left), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("post_rst_state", 32'({o_game_active, o_game_over, o_mole_visible}), 0);
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/whack_game_controller.md
# whack_game_controller

Round sequencer for the whack-a-mole game. It starts and times a game, latches each new mole position from the mole position generator, and judges the five debounced hole buttons against that position. It keeps the score and requests a new mole position after every hit. It sits between the button debouncers, the mole position generator (driving its change-position request and watching its position-changed strobe) and the seven-segment/LED display logic.

## Interface
- CLKS_PER_SEC, 100000000, clock cycles per game second
- GAME_SECONDS, 30, game length in seconds (1..63)
- LOCKOUT_CYCLES, 25000000, button lockout after a hit or miss (≥1)
- SCORE_W, 8, score width
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle start pulse
- i_btn  in  5  one-cycle debounced press pulses, bit n = hole n
- i_mole_position  in  3  generator position, 0..4 valid, 5 = no mole
- i_position_changed  in  1  generator strobe, i_mole_position valid this cycle
- o_change_position  out  1  one-cycle request for a new mole position
- o_mole_visible  out  1  armed mole present and game running
- o_mole_hole  out  3  latched hole index, 5 when none
- o_score  out  SCORE_W  hits this game, saturating
- o_time_left  out  6  seconds remaining
- o_game_active  out  1  state is PLAYING or LOCKOUT
- o_game_over  out  1  state is GAME_OVER
- o_hit, o_miss  out  1  one-cycle judgement strobes

## Operation
- States: IDLE, PLAYING, LOCKOUT, GAME_OVER.
- **Reset:** state is IDLE and every output is 0, except o_mole_hole = 5. The armed flag is 0.
- **Game start:** i_start in IDLE or GAME_OVER does all of the following, then enters PLAYING:
  - score := 0
  - time_left := GAME_SECONDS
  - second counter := 0
  - armed := 0
  - pulse o_change_position
- **i_start in PLAYING or LOCKOUT** is ignored.
- **Position latching:** on any i_position_changed while the game is active:
  - o_mole_hole := i_mole_position
  - armed := (i_mole_position ≤ 4)
- **Position strobes in IDLE or GAME_OVER** are ignored.
- **Judging (PLAYING, armed, i_btn ≠ 0):**
  - Exactly one bit set and it matches o_mole_hole:
    - hit: pulse o_hit
    - score := score + 1, saturating at all-ones
    - armed := 0
    - pulse o_change_position
    - enter LOCKOUT
  - Any other nonzero pattern, including multiple bits:
    - miss: pulse o_miss
    - score unchanged
    - mole stays armed
    - enter LOCKOUT
- **Ignored presses:** buttons in PLAYING while not armed, and all buttons in LOCKOUT, IDLE or GAME_OVER, are ignored with no strobe.
- **LOCKOUT:** counts LOCKOUT_CYCLES, then returns to PLAYING. Position latching continues during LOCKOUT.
- **Timer:** runs in PLAYING and LOCKOUT.
  - The second counter wraps at CLKS_PER_SEC−1.
  - Each wrap decrements time_left.
  - The decrement that reaches 0 moves the block to GAME_OVER the same edge and clears armed.
- **Simultaneous events:**
  - Expiry edge beats a button press on the same edge: no strobe, no score change.
  - A hit and i_position_changed on the same edge: the hit clears armed, then the new position is latched and armed per its value (the new mole wins).
- **GAME_OVER:** o_score and o_mole_hole hold. o_mole_visible = 0.
- **o_mole_visible** = armed & o_game_active.

## Timing
- All outputs are registered. Strobes are exactly one cycle.
- Button pulse on edge k gives o_hit/o_miss and o_change_position high during cycle k+1.
- Score updates at the same edge as the strobe.
- With the generator answering in one cycle, the new mole is armed at edge k+2.
- The LOCKOUT → PLAYING transition occurs LOCKOUT_CYCLES edges after LOCKOUT entry.
- After start, time_left reaches 0 exactly GAME_SECONDS×CLKS_PER_SEC edges later.
- Reset asserted mid-game returns the block to the reset values immediately (asynchronous). Deassertion is synchronous to i_clk upstream.

## Structure
- Shared package whack_pkg holds:
  - state encoding (2 bits)
  - NUM_HOLES = 5
  - NO_MOLE = 3'd5
- Sub-module game_timer holds the second counter, the time_left down-counter and the expiry pulse. It has load and enable inputs.
- The FSM, lockout counter, latch and score stay in the top level.

## Test plan
All scenarios use CLKS_PER_SEC=10, GAME_SECONDS=3, LOCKOUT_CYCLES=4, with a 1-cycle generator model.
- **Reset then start:**
  - After reset, outputs are 0 and o_mole_hole = 5.
  - i_start → o_change_position for 1 cycle, o_game_active = 1, o_time_left = 3.
- **Hit:**
  - Mole at 2, i_btn = 5'b00100 → o_hit for 1 cycle, o_score = 1, o_change_position for 1 cycle.
  - LOCKOUT lasts 4 cycles. A press during it gives no strobe.
- **Misses:**
  - Mole at 2, i_btn = 5'b01000 → o_miss, o_score unchanged, mole still visible.
  - i_btn = 5'b00110 → o_miss.
- **No mole:** i_mole_position = 5 latched; any button press → no strobe, o_mole_visible = 0.
- **Expiry:**
  - After 30 cycles of play: o_time_left = 0 and o_game_over = 1.
  - A button press on the expiry edge produces no strobe.
  - A later i_start gives o_score = 0 and o_time_left = 3.
- **Saturation and mid-game reset:**
  - SCORE_W=2: four hits → o_score = 3.
  - i_rst_n low mid-LOCKOUT → IDLE immediately.
